if_id_ex_tracker: RTL and testbench



---
 rtl/if_id_ex_tracker.sv | 255 +++++++++++++++++++++++++
 tb/tb_if_id_ex_tracker.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_ex_tracker.sv
// if_id_ex_tracker: passive trace of each instruction through IF, ID and EX.
// Three chained trackers stamp stage start/end times from the shared cycle
// counter and emit one trace record per instruction toward wb_tracker.
// The block only observes the core; it never drives any core signal.
module if_id_ex_tracker #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8    // power of 2, at least 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic signed [31:0]                   counter,
  input  logic                                 if_ready,
  input  logic                                 instr_req,
  input  logic                                 instr_grant,
  input  logic                                 instr_rvalid,
  input  logic [ADDR_WIDTH-1:0]                instr_addr,
  input  logic [DATA_WIDTH-1:0]                instr_rdata,
  input  logic                                 id_ready,
  input  logic                                 jump_done,
  input  logic                                 data_req_id,
  input  logic                                 ex_ready,
  input  logic                                 data_req_i,
  input  logic                                 data_gnt_i,
  input  logic [ADDR_WIDTH-1:0]                data_addr_i,
  output logic                                 if_data_valid,
  output logic [2*ADDR_WIDTH+DATA_WIDTH+192:0] if_data_o,
  output logic                                 id_data_ready,
  output logic [2*ADDR_WIDTH+DATA_WIDTH+192:0] id_data_o,
  output logic                                 ex_data_ready,
  output logic [2*ADDR_WIDTH+DATA_WIDTH+192:0] ex_data_o
);

  // Trace record; fields not yet written by a stage stay zero.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] instr;
    logic [31:0]           if_start;
    logic [31:0]           if_end;
    logic [31:0]           id_start;
    logic [31:0]           id_end;
    logic [31:0]           ex_start;
    logic [31:0]           ex_end;
    logic                  mem_access;
    logic [ADDR_WIDTH-1:0] mem_addr;
  } rec_t;

  typedef enum logic { IF_IDLE, IF_WAIT_RVALID } if_state_t;
  typedef enum logic { EX_IDLE, EX_BUSY }        ex_state_t;

  localparam int PW    = $clog2(BUFFER_DEPTH);
  localparam int CNT_W = PW + 1;

  // Timestamping helpers: each stage only ever fills in its own fields.
  function automatic rec_t open_fetch(input logic [ADDR_WIDTH-1:0] a,
                                      input logic signed [31:0]    ts);
    rec_t r;
    r          = '0;
    r.addr     = a;
    r.if_start = ts;
    return r;
  endfunction

  function automatic rec_t close_fetch(input rec_t                  r_in,
                                       input logic [DATA_WIDTH-1:0] word,
                                       input logic signed [31:0]    ts);
    rec_t r;
    r        = r_in;
    r.instr  = word;
    r.if_end = ts;
    return r;
  endfunction

  function automatic rec_t close_decode(input rec_t               r_in,
                                        input logic signed [31:0] ts_start,
                                        input logic signed [31:0] ts_end,
                                        input logic               mem);
    rec_t r;
    r            = r_in;
    r.id_start   = ts_start;
    r.id_end     = ts_end;
    r.mem_access = mem;
    return r;
  endfunction

  function automatic rec_t open_execute(input rec_t               r_in,
                                        input logic signed [31:0] ts);
    rec_t r;
    r          = r_in;
    r.ex_start = ts;
    return r;
  endfunction

  function automatic rec_t close_execute(input rec_t                  r_in,
                                         input logic signed [31:0]    ts,
                                         input logic                  take_addr,
                                         input logic [ADDR_WIDTH-1:0] a);
    rec_t r;
    r        = r_in;
    r.ex_end = ts;
    if (take_addr) r.mem_addr = a;
    return r;
  endfunction

  // Stage outputs: _p0 = IF, _p1 = ID, _p2 = EX.
  rec_t             rec_p0, rec_p1, rec_p2;
  logic             vld_p0, vld_p1, vld_p2;

  // IF tracker state
  if_state_t        if_state;
  rec_t             if_open;
  logic             fetch_hs;

  // ID tracker state
  rec_t             fifo_mem [BUFFER_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             head_started;
  logic             head_mem;
  logic signed [31:0] head_ts;
  logic             present, start_now, started_eff, pop, accept;
  logic [CNT_W-1:0] keep;
  logic [PW-1:0]    rd_next, wr_idx;

  // EX tracker state
  ex_state_t        ex_state;
  rec_t             ex_cur;
  logic             mem_hs, complete, emit;

  assign fetch_hs = instr_req && instr_grant;
  assign mem_hs   = data_req_i && data_gnt_i;

  // ---------------- IF stage (p0) ----------------

  // Open a record on an accepted fetch, close and emit it on rvalid; a fetch
  // accepted together with rvalid opens the next record in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_state <= IF_IDLE;
      vld_p0   <= 1'b0;
      rec_p0   <= '0;
    end else begin
      vld_p0 <= 1'b0;
      case (if_state)
        IF_IDLE: begin
          if (fetch_hs) if_state <= IF_WAIT_RVALID;
        end
        IF_WAIT_RVALID: begin
          if (instr_rvalid) begin
            rec_p0 <= close_fetch(if_open, instr_rdata, counter);
            vld_p0 <= 1'b1;
            if (!fetch_hs) if_state <= IF_IDLE;
          end
        end
        default: if_state <= IF_IDLE;
      endcase
    end
  end

  // The open fetch record is data only; its validity is carried by if_state.
  always_ff @(posedge clk) begin
    if (fetch_hs && (if_state == IF_IDLE || instr_rvalid))
      if_open <= open_fetch(instr_addr, counter);
  end

  // ---------------- ID stage (p1) ----------------

  // FIFO bookkeeping. The head is stamped the first cycle if_ready is seen,
  // and may start and retire in the same cycle. Removals (pop, jump flush)
  // are applied before the incoming record claims a slot, which is why a
  // full FIFO still accepts a push when it pops.
  always_comb begin
    present     = (count != '0);
    start_now   = present && !head_started && if_ready;
    started_eff = head_started || start_now;
    pop         = present && started_eff && id_ready;
    if (jump_done) keep = (present && !pop) ? CNT_W'(1) : '0;
    else           keep = count - CNT_W'(pop);
    accept  = vld_p0 && (keep < CNT_W'(BUFFER_DEPTH));
    rd_next = rd_ptr + PW'(pop);
    wr_idx  = rd_next + keep[PW-1:0];
  end

  // Pointer/occupancy/head-flag updates and the retired-record output.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      count        <= '0;
      head_started <= 1'b0;
      head_mem     <= 1'b0;
      vld_p1       <= 1'b0;
      rec_p1       <= '0;
    end else begin
      vld_p1 <= pop;
      if (pop)
        rec_p1 <= close_decode(fifo_mem[rd_ptr],
                               start_now ? counter : head_ts,
                               counter, head_mem | data_req_id);
      rd_ptr <= rd_next;
      count  <= keep + CNT_W'(accept);
      if (pop) begin
        head_started <= 1'b0;
        head_mem     <= 1'b0;
      end else begin
        head_started <= started_eff;
        head_mem     <= head_mem | (started_eff & data_req_id);
      end
    end
  end

  // Record storage and head start stamp; stale contents are masked by count.
  always_ff @(posedge clk) begin
    if (accept)    fifo_mem[wr_idx] <= rec_p0;
    if (start_now) head_ts          <= counter;
  end

  // ---------------- EX stage (p2) ----------------

  // Completion depends on the kind of instruction: memory ops finish on the
  // data grant, others on ex_ready. An arriving record evicts the current one.
  always_comb begin
    complete = (ex_state == EX_BUSY) &&
               (ex_cur.mem_access ? mem_hs : ex_ready);
    emit     = (ex_state == EX_BUSY) && (complete || vld_p1);
  end

  // EX occupancy FSM and the emitted record toward wb_tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_state <= EX_IDLE;
      vld_p2   <= 1'b0;
      rec_p2   <= '0;
    end else begin
      vld_p2 <= emit;
      if (emit)
        rec_p2 <= close_execute(ex_cur, counter,
                                complete && ex_cur.mem_access, data_addr_i);
      if (vld_p1)        ex_state <= EX_BUSY;
      else if (complete) ex_state <= EX_IDLE;
    end
  end

  // Record held in EX; meaningful only while ex_state is BUSY.
  always_ff @(posedge clk) begin
    if (vld_p1) ex_cur <= open_execute(rec_p1, counter);
  end

  assign if_data_valid = vld_p0;
  assign if_data_o     = rec_p0;
  assign id_data_ready = vld_p1;
  assign id_data_o     = rec_p1;
  assign ex_data_ready = vld_p2;
  assign ex_data_o     = rec_p2;

endmodule

// File: tb/tb_if_id_ex_tracker.sv
// Testbench for if_id_ex_tracker: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_if_id_ex_tracker;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int RW    = 2*AW + DW + 193;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] instr;
    logic [31:0]   if_start;
    logic [31:0]   if_end;
    logic [31:0]   id_start;
    logic [31:0]   id_end;
    logic [31:0]   ex_start;
    logic [31:0]   ex_end;
    logic          mem_access;
    logic [AW-1:0] mem_addr;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic signed [31:0] counter;
  logic               if_ready, instr_req, instr_grant, instr_rvalid;
  logic [AW-1:0]      instr_addr;
  logic [DW-1:0]      instr_rdata;
  logic               id_ready, jump_done, data_req_id, ex_ready;
  logic               data_req_i, data_gnt_i;
  logic [AW-1:0]      data_addr_i;
  logic               if_data_valid, id_data_ready, ex_data_ready;
  rec_t               if_data_o, id_data_o, ex_data_o;

  if_id_ex_tracker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .counter(counter),
    .if_ready(if_ready), .instr_req(instr_req), .instr_grant(instr_grant),
    .instr_rvalid(instr_rvalid), .instr_addr(instr_addr), .instr_rdata(instr_rdata),
    .id_ready(id_ready), .jump_done(jump_done), .data_req_id(data_req_id),
    .ex_ready(ex_ready), .data_req_i(data_req_i), .data_gnt_i(data_gnt_i),
    .data_addr_i(data_addr_i),
    .if_data_valid(if_data_valid), .if_data_o(if_data_o),
    .id_data_ready(id_data_ready), .id_data_o(id_data_o),
    .ex_data_ready(ex_data_ready), .ex_data_o(ex_data_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: open fetch, queue of instructions waiting in ID, and
  // the instruction occupying EX, plus the outputs expected after each edge.
  bit          m_if_open;
  rec_t        m_if_rec;
  rec_t        m_q[$];
  bit          m_started, m_mem;
  logic [31:0] m_start_ts;
  bit          m_ex_busy;
  rec_t        m_ex_rec;
  bit          exp_if_v, exp_id_v, exp_ex_v;
  rec_t        exp_if, exp_id, exp_ex;

  task automatic model_step();
    bit   n_if_v, n_id_v, n_ex_v, done, popped;
    rec_t n_if, n_id, n_ex;
    if (rst) begin
      m_if_open = 0; m_q.delete(); m_started = 0; m_mem = 0; m_ex_busy = 0;
      exp_if_v = 0; exp_id_v = 0; exp_ex_v = 0;
      exp_if = '0; exp_id = '0; exp_ex = '0;
      return;
    end
    // EX: one instruction at a time; a newcomer evicts the current one.
    n_ex_v = 0; n_ex = exp_ex;
    if (m_ex_busy) begin
      done = m_ex_rec.mem_access ? (data_req_i && data_gnt_i) : ex_ready;
      if (done || exp_id_v) begin
        n_ex = m_ex_rec;
        n_ex.ex_end = counter;
        if (done && m_ex_rec.mem_access) n_ex.mem_addr = data_addr_i;
        n_ex_v = 1;
      end
      if (done) m_ex_busy = 0;
    end
    if (exp_id_v) begin
      m_ex_rec = exp_id;
      m_ex_rec.ex_start = counter;
      m_ex_busy = 1;
    end
    // ID: the front of the queue is the instruction in decode.
    n_id_v = 0; n_id = exp_id; popped = 0;
    if (m_q.size() > 0) begin
      if (!m_started && if_ready) begin m_started = 1; m_start_ts = counter; end
      if (m_started) begin
        m_mem = m_mem | data_req_id;
        if (id_ready) begin
          n_id = m_q.pop_front();
          n_id.id_start = m_start_ts;
          n_id.id_end = counter;
          n_id.mem_access = m_mem;
          n_id_v = 1; popped = 1; m_started = 0; m_mem = 0;
        end
      end
    end
    if (jump_done) begin
      if (popped) m_q.delete();
      else while (m_q.size() > 1) void'(m_q.pop_back());
    end
    if (exp_if_v && m_q.size() < DEPTH) m_q.push_back(exp_if);
    // IF: close on rvalid, then a free tracker accepts a new fetch.
    n_if_v = 0; n_if = exp_if;
    if (m_if_open && instr_rvalid) begin
      n_if = m_if_rec;
      n_if.instr = instr_rdata;
      n_if.if_end = counter;
      n_if_v = 1; m_if_open = 0;
    end
    if (!m_if_open && instr_req && instr_grant) begin
      m_if_rec = '0;
      m_if_rec.addr = instr_addr;
      m_if_rec.if_start = counter;
      m_if_open = 1;
    end
    exp_if_v = n_if_v; exp_if = n_if;
    exp_id_v = n_id_v; exp_id = n_id;
    exp_ex_v = n_ex_v; exp_ex = n_ex;
  endtask

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_model();
    chk("if_valid", if_data_valid, exp_if_v);
    chk("if_rec",   if_data_o,     exp_if);
    chk("id_ready", id_data_ready, exp_id_v);
    chk("id_rec",   id_data_o,     exp_id);
    chk("ex_ready", ex_data_ready, exp_ex_v);
    chk("ex_rec",   ex_data_o,     exp_ex);
  endtask

  task automatic cyc(input logic signed [31:0] c);
    counter = c;
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic clr_in();
    if_ready = 0; instr_req = 0; instr_grant = 0; instr_rvalid = 0;
    instr_addr = '0; instr_rdata = '0; id_ready = 0; jump_done = 0;
    data_req_id = 0; ex_ready = 0; data_req_i = 0; data_gnt_i = 0; data_addr_i = '0;
  endtask

  initial begin
    rec_t e;
    logic signed [31:0] cnt;
    clr_in(); rst = 1; counter = 0;
    cyc(0);
    cyc(1);
    chk("reset_if_valid", if_data_valid, 0);
    chk("reset_ex_rec", ex_data_o, '0);
    rst = 0;

    // Fetch: addr 0x80 at 10, data 0x13 at 12
    clr_in(); instr_req = 1; instr_grant = 1; instr_addr = 32'h80; cyc(10);
    clr_in(); cyc(11);
    clr_in(); instr_rvalid = 1; instr_rdata = 32'h13; cyc(12);
    e = '0; e.addr = 32'h80; e.instr = 32'h13; e.if_start = 10; e.if_end = 12;
    chk("fetch_valid", if_data_valid, 1);
    chk("fetch_rec", if_data_o, e);
    clr_in(); cyc(12);
    chk("fetch_pulse_once", if_data_valid, 0);

    // ALU path through ID and EX
    clr_in(); if_ready = 1; cyc(13);
    clr_in(); cyc(14);
    clr_in(); id_ready = 1; cyc(15);
    e.id_start = 13; e.id_end = 15;
    chk("alu_id_ready", id_data_ready, 1);
    chk("alu_id_rec", id_data_o, e);
    clr_in(); cyc(15);
    clr_in(); ex_ready = 1; cyc(16);
    e.ex_start = 15; e.ex_end = 16;
    chk("alu_ex_ready", ex_data_ready, 1);
    chk("alu_ex_rec", ex_data_o, e);

    // Load: completes on the data grant, capturing the address
    clr_in(); instr_req = 1; instr_grant = 1; instr_addr = 32'h84; cyc(17);
    clr_in(); instr_rvalid = 1; instr_rdata = 32'h03; cyc(18);
    clr_in(); cyc(18);
    clr_in(); if_ready = 1; data_req_id = 1; cyc(19);
    clr_in(); id_ready = 1; cyc(19);
    clr_in(); cyc(19);
    clr_in(); data_req_i = 1; data_gnt_i = 1; data_addr_i = 32'h1000; cyc(20);
    chk("load_ex_ready", ex_data_ready, 1);
    chk("load_mem_access", ex_data_o.mem_access, 1);
    chk("load_mem_addr", ex_data_o.mem_addr, 32'h1000);
    chk("load_ex_end", ex_data_o.ex_end, 20);

    // FIFO boundary: nine fetches, eight retained
    clr_in(); instr_req = 1; instr_grant = 1; instr_addr = 32'h100; cyc(100);
    for (int k = 1; k <= 8; k++) begin
      clr_in(); instr_rvalid = 1; instr_rdata = k - 1;
      instr_req = 1; instr_grant = 1; instr_addr = 32'h100 + 4*k; cyc(100 + k);
    end
    clr_in(); instr_rvalid = 1; instr_rdata = 8; cyc(109);
    clr_in(); cyc(110);
    for (int k = 0; k < 8; k++) begin
      clr_in(); if_ready = 1; id_ready = 1; cyc(111 + k);
      chk("fifo_pop_ready", id_data_ready, 1);
      chk("fifo_pop_addr", id_data_o.addr, 32'h100 + 4*k);
    end
    clr_in(); if_ready = 1; id_ready = 1; cyc(119);
    chk("fifo_ninth_dropped", id_data_ready, 0);
    clr_in(); ex_ready = 1; cyc(120);

    // jump_done with three buffered records keeps only the head
    clr_in(); instr_req = 1; instr_grant = 1; instr_addr = 32'h200; cyc(130);
    clr_in(); instr_rvalid = 1; instr_req = 1; instr_grant = 1; instr_addr = 32'h204; cyc(131);
    clr_in(); instr_rvalid = 1; instr_req = 1; instr_grant = 1; instr_addr = 32'h208; cyc(132);
    clr_in(); instr_rvalid = 1; cyc(133);
    clr_in(); cyc(134);
    clr_in(); jump_done = 1; cyc(135);
    clr_in(); instr_req = 1; instr_grant = 1; instr_addr = 32'h20C; cyc(136);
    clr_in(); instr_rvalid = 1; cyc(137);
    clr_in(); cyc(138);
    clr_in(); if_ready = 1; id_ready = 1; cyc(139);
    chk("jump_head_addr", id_data_o.addr, 32'h200);
    clr_in(); if_ready = 1; id_ready = 1; cyc(140);
    chk("jump_second_addr", id_data_o.addr, 32'h20C);
    chk("jump_second_ready", id_data_ready, 1);
    clr_in(); if_ready = 1; id_ready = 1; cyc(141);
    chk("jump_drained", id_data_ready, 0);
    clr_in(); ex_ready = 1; cyc(142);

    // Reset with a fetch in flight and EX busy
    clr_in(); instr_req = 1; instr_grant = 1; instr_addr = 32'h300; cyc(150);
    clr_in(); instr_rvalid = 1; instr_rdata = 32'h33; cyc(151);
    clr_in(); cyc(152);
    clr_in(); if_ready = 1; id_ready = 1; cyc(153);
    clr_in(); cyc(154);
    clr_in(); instr_req = 1; instr_grant = 1; instr_addr = 32'h304; cyc(155);
    clr_in(); rst = 1; instr_rvalid = 1; ex_ready = 1; cyc(156);
    rst = 0;
    chk("rst_if_valid", if_data_valid, 0);
    chk("rst_if_rec", if_data_o, '0);
    chk("rst_id_ready", id_data_ready, 0);
    chk("rst_id_rec", id_data_o, '0);
    chk("rst_ex_ready", ex_data_ready, 0);
    chk("rst_ex_rec", ex_data_o, '0);
    clr_in(); instr_rvalid = 1; instr_rdata = 32'h44; ex_ready = 1; cyc(157);
    chk("rst_late_rvalid", if_data_valid, 0);
    chk("rst_ex_discarded", ex_data_ready, 0);

    // Randomized traffic, counter wrapping through the signed maximum
    cnt = 32'sh7FFF_FF00;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        rst          = ($urandom_range(0, 299) == 0);
        instr_req    = ($urandom_range(0, 1) == 0);
        instr_grant  = ($urandom_range(0, 2) != 0);
        instr_rvalid = ($urandom_range(0, 1) == 0);
        instr_addr   = $urandom;
        instr_rdata  = $urandom;
        if_ready     = ($urandom_range(0, 1) == 0);
        id_ready     = (ph == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
        jump_done    = ($urandom_range(0, 19) == 0);
        data_req_id  = ($urandom_range(0, 2) == 0);
        ex_ready     = ($urandom_range(0, 1) == 0);
        data_req_i   = ($urandom_range(0, 1) == 0);
        data_gnt_i   = ($urandom_range(0, 1) == 0);
        data_addr_i  = $urandom;
        cnt = cnt + $urandom_range(0, 2);
        cyc(cnt);
      end
    end
    rst = 0; clr_in(); cyc(cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
